// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache eviction path.
package cache_pkg;

  localparam int unsigned MAX_WAYS  = 512;
  localparam int unsigned WAY_IDX_W = $clog2(MAX_WAYS);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StRead,
    StWaitData,
    StWriteback,
    StAllocate
  } evict_state_t;

  // Isolates the lowest set bit of a way vector.
  function automatic logic [MAX_WAYS-1:0] onehot_lowest(input logic [MAX_WAYS-1:0] vec);
    return vec & (~vec + 1'b1);
  endfunction

endpackage

// File: rtl/way_priority_encoder.sv
// Lowest-index set bit of a way vector, plus an any-set flag.
module way_priority_encoder #(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned IDX_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic [NUM_WAYS-1:0] vec,
  output logic [IDX_W-1:0]    idx,
  output logic                any
);

  always_comb begin
    idx = '0;
    any = |vec;
    // Scan downwards so the lowest set bit is written last and wins.
    for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/eviction_controller.sv
// Resolves a cache-miss allocation to one way: invalid way first, else the LRU target,
// writing back a dirty victim before the allocate pulse.
module eviction_controller
  import cache_pkg::*;
#(
  parameter int unsigned NUM_WAYS   = 512,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 512,
  localparam int unsigned IDX_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic                  eviction_ready,
  input  logic [NUM_WAYS-1:0]   eviction_target,
  input  logic [NUM_WAYS-1:0]   way_valid,
  input  logic [NUM_WAYS-1:0]   way_dirty,
  output logic                  victim_rd_en,
  output logic [IDX_W-1:0]      victim_rd_idx,
  input  logic [ADDR_WIDTH-1:0] victim_addr,
  input  logic [LINE_WIDTH-1:0] victim_data,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [LINE_WIDTH-1:0] wb_data,
  output logic [NUM_WAYS-1:0]   invalidate_way,
  output logic [NUM_WAYS-1:0]   allocate_way,
  output logic [ADDR_WIDTH-1:0] alloc_addr,
  output logic [15:0]           wb_count
);

  evict_state_t state_q, state_d;

  logic [IDX_W-1:0]      victim_idx_q, victim_idx_d;
  logic [ADDR_WIDTH-1:0] miss_addr_q;
  logic                  victim_rd_en_q;
  logic                  wb_valid_q;
  logic [ADDR_WIDTH-1:0] wb_addr_q;
  logic [LINE_WIDTH-1:0] wb_data_q;
  logic [NUM_WAYS-1:0]   allocate_way_q;
  logic [ADDR_WIDTH-1:0] alloc_addr_q;
  logic [15:0]           wb_count_q;

  logic [NUM_WAYS-1:0] invalid_vec;
  logic [IDX_W-1:0]    inv_idx, tgt_idx;
  logic                inv_any, tgt_any;
  logic [NUM_WAYS-1:0] victim_onehot_d;

  assign invalid_vec = ~way_valid;

  way_priority_encoder #(
    .NUM_WAYS (NUM_WAYS),
    .IDX_W    (IDX_W)
  ) u_invalid_enc (
    .vec (invalid_vec),
    .idx (inv_idx),
    .any (inv_any)
  );

  way_priority_encoder #(
    .NUM_WAYS (NUM_WAYS),
    .IDX_W    (IDX_W)
  ) u_target_enc (
    .vec (eviction_target),
    .idx (tgt_idx),
    .any (tgt_any)
  );

  // invalidate_way is decoded from the SELECT decision so it lands in the same cycle the
  // victim is chosen; every other output is a register.
  always_comb begin
    state_d        = state_q;
    victim_idx_d   = victim_idx_q;
    invalidate_way = '0;
    unique case (state_q)
      StIdle: begin
        if (miss_valid) state_d = StSelect;
      end
      StSelect: begin
        if (inv_any) begin
          victim_idx_d = inv_idx;
          state_d      = StAllocate;
        end else if (eviction_ready && tgt_any) begin
          victim_idx_d   = tgt_idx;
          invalidate_way = {{(NUM_WAYS-1){1'b0}}, 1'b1} << tgt_idx;
          state_d        = way_dirty[tgt_idx] ? StRead : StAllocate;
        end
      end
      StRead:      state_d = StWaitData;
      StWaitData:  state_d = StWriteback;
      StWriteback: begin
        if (wb_ready) state_d = StAllocate;
      end
      StAllocate:  state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  assign victim_onehot_d = {{(NUM_WAYS-1){1'b0}}, 1'b1} << victim_idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      victim_idx_q   <= '0;
      miss_addr_q    <= '0;
      victim_rd_en_q <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
      allocate_way_q <= '0;
      alloc_addr_q   <= '0;
      wb_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      victim_idx_q   <= victim_idx_d;
      victim_rd_en_q <= (state_d == StRead);
      wb_valid_q     <= (state_d == StWriteback);
      allocate_way_q <= (state_d == StAllocate) ? victim_onehot_d : '0;
      if (state_q == StIdle && miss_valid) begin
        miss_addr_q <= miss_addr;
      end
      if (state_q == StWaitData) begin
        wb_addr_q <= victim_addr;
        wb_data_q <= victim_data;
      end
      if (state_q == StWriteback && wb_ready && wb_count_q != 16'hFFFF) begin
        wb_count_q <= wb_count_q + 16'd1;
      end
      if (state_d == StAllocate) begin
        alloc_addr_q <= miss_addr_q;
      end
    end
  end

  assign miss_ready    = (state_q == StIdle);
  assign victim_rd_en  = victim_rd_en_q;
  assign victim_rd_idx = victim_idx_q;
  assign wb_valid      = wb_valid_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data       = wb_data_q;
  assign allocate_way  = allocate_way_q;
  assign alloc_addr    = alloc_addr_q;
  assign wb_count      = wb_count_q;

endmodule

// File: tb/tb_eviction_controller.sv
// Directed bench for eviction_controller with a 4-way set.
module tb_eviction_controller;

  localparam int unsigned NUM_WAYS   = 4;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned LINE_WIDTH = 64;

  logic                  clk;
  logic                  rst;
  logic                  miss_valid;
  logic                  miss_ready;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic                  eviction_ready;
  logic [NUM_WAYS-1:0]   eviction_target;
  logic [NUM_WAYS-1:0]   way_valid;
  logic [NUM_WAYS-1:0]   way_dirty;
  logic                  victim_rd_en;
  logic [1:0]            victim_rd_idx;
  logic [ADDR_WIDTH-1:0] victim_addr;
  logic [LINE_WIDTH-1:0] victim_data;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [LINE_WIDTH-1:0] wb_data;
  logic [NUM_WAYS-1:0]   invalidate_way;
  logic [NUM_WAYS-1:0]   allocate_way;
  logic [ADDR_WIDTH-1:0] alloc_addr;
  logic [15:0]           wb_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [ADDR_WIDTH-1:0] model_addr;
  logic [LINE_WIDTH-1:0] model_data;

  eviction_controller #(
    .NUM_WAYS   (NUM_WAYS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LINE_WIDTH (LINE_WIDTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .miss_valid      (miss_valid),
    .miss_ready      (miss_ready),
    .miss_addr       (miss_addr),
    .eviction_ready  (eviction_ready),
    .eviction_target (eviction_target),
    .way_valid       (way_valid),
    .way_dirty       (way_dirty),
    .victim_rd_en    (victim_rd_en),
    .victim_rd_idx   (victim_rd_idx),
    .victim_addr     (victim_addr),
    .victim_data     (victim_data),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .invalidate_way  (invalidate_way),
    .allocate_way    (allocate_way),
    .alloc_addr      (alloc_addr),
    .wb_count        (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag/data array: answers a read strobe one cycle later, otherwise returns junk.
  always @(posedge clk) begin
    victim_addr <= victim_rd_en ? model_addr : 32'hDEAD_0000;
    victim_data <= victim_rd_en ? model_data : '0;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_miss(input logic [ADDR_WIDTH-1:0] addr);
    miss_valid = 1'b1;
    miss_addr  = addr;
    tick();
    miss_valid = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    miss_valid      = 1'b0;
    miss_addr       = '0;
    eviction_ready  = 1'b0;
    eviction_target = '0;
    way_valid       = '1;
    way_dirty       = '0;
    wb_ready        = 1'b0;
    model_addr      = 32'h0000_0ABC;
    model_data      = 64'h1234_5678_9ABC_DEF0;
    tick();
    tick();
    check_eq("rst_miss_ready", 64'(miss_ready), 64'd1);
    check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
    check_eq("rst_rd_en", 64'(victim_rd_en), 64'd0);
    check_eq("rst_alloc", 64'(allocate_way), 64'd0);
    check_eq("rst_wb_count", 64'(wb_count), 64'd0);
    rst = 1'b0;
    tick();

    // Invalid way 2 available.
    way_valid = 4'b1011;
    issue_miss(32'h100);
    check_eq("inv_in_select_ready", 64'(miss_ready), 64'd0);
    check_eq("inv_no_invalidate", 64'(invalidate_way), 64'd0);
    tick();
    check_eq("inv_alloc_way", 64'(allocate_way), 64'b0100);
    check_eq("inv_alloc_addr", 64'(alloc_addr), 64'h100);
    check_eq("inv_no_wb", 64'(wb_valid), 64'd0);
    tick();
    check_eq("inv_alloc_pulse_end", 64'(allocate_way), 64'd0);
    check_eq("inv_back_idle", 64'(miss_ready), 64'd1);

    // Clean eviction of way 1.
    way_valid       = 4'b1111;
    eviction_ready  = 1'b1;
    eviction_target = 4'b0010;
    issue_miss(32'h200);
    check_eq("clean_invalidate", 64'(invalidate_way), 64'b0010);
    tick();
    check_eq("clean_alloc_way", 64'(allocate_way), 64'b0010);
    check_eq("clean_invalidate_end", 64'(invalidate_way), 64'd0);
    check_eq("clean_no_rd", 64'(victim_rd_en), 64'd0);
    tick();

    // Dirty eviction of way 3 with a stalled writeback and a target change mid-flight.
    eviction_target = 4'b1000;
    way_dirty       = 4'b1000;
    issue_miss(32'h300);
    check_eq("dirty_invalidate", 64'(invalidate_way), 64'b1000);
    tick();
    check_eq("dirty_rd_en", 64'(victim_rd_en), 64'd1);
    check_eq("dirty_rd_idx", 64'(victim_rd_idx), 64'd3);
    tick();
    check_eq("dirty_rd_pulse_end", 64'(victim_rd_en), 64'd0);
    tick();
    check_eq("dirty_wb_valid", 64'(wb_valid), 64'd1);
    check_eq("dirty_wb_addr", 64'(wb_addr), 64'hABC);
    check_eq("dirty_wb_data", 64'(wb_data), 64'h1234_5678_9ABC_DEF0);
    eviction_target = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_wb_valid", 64'(wb_valid), 64'd1);
      check_eq("stall_wb_addr", 64'(wb_addr), 64'hABC);
      check_eq("stall_no_alloc", 64'(allocate_way), 64'd0);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check_eq("dirty_alloc_way", 64'(allocate_way), 64'b1000);
    check_eq("dirty_alloc_addr", 64'(alloc_addr), 64'h300);
    check_eq("dirty_wb_dropped", 64'(wb_valid), 64'd0);
    check_eq("dirty_wb_count", 64'(wb_count), 64'd1);
    tick();

    // Policy not ready for 5 cycles, then a clean evict of way 0.
    eviction_ready = 1'b0;
    way_dirty      = 4'b0000;
    issue_miss(32'h400);
    for (int i = 0; i < 5; i++) begin
      check_eq("wait_no_invalidate", 64'(invalidate_way), 64'd0);
      tick();
      check_eq("wait_busy", 64'(miss_ready), 64'd0);
      check_eq("wait_no_alloc", 64'(allocate_way), 64'd0);
    end
    eviction_ready = 1'b1;
    #1;
    check_eq("wait_invalidate", 64'(invalidate_way), 64'b0001);
    tick();
    check_eq("wait_alloc_way", 64'(allocate_way), 64'b0001);
    check_eq("wait_alloc_addr", 64'(alloc_addr), 64'h400);
    tick();

    // Multi-hot target: lowest set bit wins.
    eviction_target = 4'b0110;
    issue_miss(32'h500);
    check_eq("multi_invalidate", 64'(invalidate_way), 64'b0010);
    tick();
    check_eq("multi_alloc_way", 64'(allocate_way), 64'b0010);
    tick();

    // Reset while a writeback is pending.
    eviction_target = 4'b0001;
    way_dirty       = 4'b0001;
    issue_miss(32'h600);
    tick();
    tick();
    tick();
    check_eq("rstwb_wb_valid_before", 64'(wb_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rstwb_wb_valid", 64'(wb_valid), 64'd0);
    check_eq("rstwb_miss_ready", 64'(miss_ready), 64'd1);
    check_eq("rstwb_wb_count", 64'(wb_count), 64'd0);
    tick();
    check_eq("rstwb_discarded", 64'(allocate_way), 64'd0);
    check_eq("rstwb_idle", 64'(miss_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
